// File: rtl/d_trigger_arbiter_if.sv
// Write-request / shared-register bus between the requesters and d_trigger_arbiter.
// master = requester side, slave = arbiter side.
interface d_trigger_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] data;
  logic [N-1:0]       grant;
  logic [WIDTH-1:0]   out;
  logic [2:0]         owner;
  logic               busy;
  logic [7:0]         wr_count;

  modport master (output req, data, input grant, out, owner, busy, wr_count);
  modport slave  (input req, data, output grant, out, owner, busy, wr_count);
endinterface

// File: rtl/d_trigger_arbiter.sv
// Round-robin write arbiter owning one shared WIDTH-bit register, with a HOLD-cycle
// stable window after each write. Optional macro D_TRIGGER_ARB_PRIO_EN gives requester 0 absolute priority.
module d_trigger_arbiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  assign dout = sel ? din : '0;
endmodule

module d_trigger_arbiter #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int HOLD  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  d_trigger_arbiter_if.slave    bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]                  state;
  logic [3:0]                  cnt;
  logic [2:0]                  ptr;
  logic [N-1:0]                grant;
  logic [WIDTH-1:0]            out;
  logic [2:0]                  owner;
  logic [7:0]                  wr_count;

  logic [N-1:0][WIDTH-1:0]     lane_data;
  logic [N-1:0][WIDTH-1:0]     lane_sel_data;
  logic [WIDTH-1:0]            wdata;
  logic [N-1:0]                win_oh;
  logic [2:0]                  win_idx;
  logic                        win_vld;

  assign lane_data = bus.data;

  // Search starts just past the last winner, so a held request waits its turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
`ifdef D_TRIGGER_ARB_PRIO_EN
    if (bus.req[0]) win_vld = 1'b1;
`endif
    for (int k = 1; k <= N; k++) begin
      if (!win_vld && bus.req[(int'(ptr) + k) % N]) begin
        win_vld = 1'b1;
        win_idx = 3'((int'(ptr) + k) % N);
      end
    end
    win_oh = win_vld ? (N'(1) << win_idx) : '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      d_trigger_arbiter_lane #(.WIDTH(WIDTH)) u_lane (
        .sel  (win_oh[gi]),
        .din  (lane_data[gi]),
        .dout (lane_sel_data[gi])
      );
    end
  endgenerate

  always_comb begin
    wdata = '0;
    for (int i = 0; i < N; i++) wdata = wdata | lane_sel_data[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      ptr      <= 3'(N - 1);
      grant    <= '0;
      out      <= '0;
      owner    <= 3'(N - 1);
      wr_count <= '0;
    end else begin
      grant <= '0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            out      <= wdata;
            grant    <= win_oh;
            owner    <= win_idx;
            wr_count <= wr_count + 8'd1;
`ifdef D_TRIGGER_ARB_PRIO_EN
            // A priority grant to requester 0 leaves the rotation untouched.
            if (win_idx != 3'd0) ptr <= win_idx;
`else
            ptr <= win_idx;
`endif
            if (HOLD > 0) begin
              state <= S_HOLD;
              cnt   <= 4'(HOLD);
            end
          end
        end
        S_HOLD: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant    = grant;
  assign bus.out      = out;
  assign bus.owner    = owner;
  assign bus.busy     = (state == S_HOLD);
  assign bus.wr_count = wr_count;
endmodule

// File: tb/tb_d_trigger_arbiter.sv
// Directed bench: HOLD=2 instance driven from a vector table, HOLD=0 instance
// used for rotation, priority-mode and counter-wrap sequences.
module tb_d_trigger_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  d_trigger_arbiter_if #(.WIDTH(8), .N(4)) bh ();
  d_trigger_arbiter_if #(.WIDTH(8), .N(4)) bz ();

  d_trigger_arbiter #(.WIDTH(8), .N(4), .HOLD(2)) u_h (.clk(clk), .reset(reset), .bus(bh));
  d_trigger_arbiter #(.WIDTH(8), .N(4), .HOLD(0)) u_z (.clk(clk), .reset(reset), .bus(bz));

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [7:0]  out;
    logic [2:0]  owner;
    logic        busy;
    logic [7:0]  wr;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic [3:0] r, logic [31:0] d, logic [3:0] g,
                              logic [7:0] o, logic [2:0] ow, logic b, logic [7:0] w);
    vec_t v;
    v.req = r; v.data = d; v.grant = g; v.out = o; v.owner = ow; v.busy = b; v.wr = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " h.out"},   32'(bh.out), 0);
    chk({tag, " h.grant"}, 32'(bh.grant), 0);
    chk({tag, " h.owner"}, 32'(bh.owner), 3);
    chk({tag, " h.busy"},  32'(bh.busy), 0);
    chk({tag, " h.wr"},    32'(bh.wr_count), 0);
    chk({tag, " z.out"},   32'(bz.out), 0);
    chk({tag, " z.owner"}, 32'(bz.owner), 3);
    chk({tag, " z.wr"},    32'(bz.wr_count), 0);
  endtask

  initial begin
    int seq[6];
    logic [3:0] eg;
    logic [7:0] eo;
    logic [31:0] lanes;

    tbl[0]  = mk(4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 3'd2, 1'b1, 8'd1);
    tbl[1]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'hA5, 3'd2, 1'b1, 8'd1);
    tbl[2]  = mk(4'b0000, 32'h0000_0000, 4'b0000, 8'hA5, 3'd2, 1'b0, 8'd1);
    tbl[3]  = mk(4'b0001, 32'h0000_0011, 4'b0001, 8'h11, 3'd0, 1'b1, 8'd2);
    tbl[4]  = mk(4'b0010, 32'h0000_2211, 4'b0000, 8'h11, 3'd0, 1'b1, 8'd2);
    tbl[5]  = mk(4'b0010, 32'h0000_2211, 4'b0000, 8'h11, 3'd0, 1'b0, 8'd2);
    tbl[6]  = mk(4'b0000, 32'h0000_2211, 4'b0000, 8'h11, 3'd0, 1'b0, 8'd2);
    tbl[7]  = mk(4'b1110, 32'h4332_2110, 4'b0010, 8'h21, 3'd1, 1'b1, 8'd3);
    tbl[8]  = mk(4'b1110, 32'h4332_2110, 4'b0000, 8'h21, 3'd1, 1'b1, 8'd3);
    tbl[9]  = mk(4'b1110, 32'h4332_2110, 4'b0000, 8'h21, 3'd1, 1'b0, 8'd3);
    tbl[10] = mk(4'b1110, 32'h4332_2110, 4'b0100, 8'h32, 3'd2, 1'b1, 8'd4);
    tbl[11] = mk(4'b1110, 32'h4332_2110, 4'b0000, 8'h32, 3'd2, 1'b1, 8'd4);
    tbl[12] = mk(4'b1110, 32'h4332_2110, 4'b0000, 8'h32, 3'd2, 1'b0, 8'd4);
    tbl[13] = mk(4'b1110, 32'h4332_2110, 4'b1000, 8'h43, 3'd3, 1'b1, 8'd5);
    tbl[14] = mk(4'b1110, 32'h4332_2110, 4'b0000, 8'h43, 3'd3, 1'b1, 8'd5);
    tbl[15] = mk(4'b1110, 32'h4332_2110, 4'b0000, 8'h43, 3'd3, 1'b0, 8'd5);
    tbl[16] = mk(4'b1110, 32'h4332_2110, 4'b0010, 8'h21, 3'd1, 1'b1, 8'd6);

    // Reset held with random traffic on both instances
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bh.req = 4'($urandom); bh.data = $urandom;
      bz.req = 4'($urandom); bz.data = $urandom;
      step();
    end
    chk_reset("reset");
    bh.req = '0; bh.data = '0; bz.req = '0; bz.data = '0;
    reset = 1'b1;

    // Table: single request, hold blocking, round-robin with hold spacing
    for (int i = 0; i < 17; i++) begin
      bh.req  = tbl[i].req;
      bh.data = tbl[i].data;
      step();
      chk($sformatf("v%0d grant", i), 32'(bh.grant),    32'(tbl[i].grant));
      chk($sformatf("v%0d out", i),   32'(bh.out),      32'(tbl[i].out));
      chk($sformatf("v%0d owner", i), 32'(bh.owner),    32'(tbl[i].owner));
      chk($sformatf("v%0d busy", i),  32'(bh.busy),     32'(tbl[i].busy));
      chk($sformatf("v%0d wr", i),    32'(bh.wr_count), 32'(tbl[i].wr));
    end

    // Mid-HOLD asynchronous reset after a write of 3C
    bh.req = '0;
    step(); step();
    bh.req = 4'b0001; bh.data = 32'h0000_003C;
    step();
    chk("w3c grant", 32'(bh.grant), 32'h1);
    chk("w3c out",   32'(bh.out),   32'h3C);
    bh.req = '0;
    step();
    chk("w3c busy", 32'(bh.busy), 1);
    reset = 1'b0;
    #2;
    chk_reset("async");
    reset = 1'b1;
    bh.req = 4'b0001; bh.data = 32'h0000_0055;
    step();
    chk("post grant", 32'(bh.grant), 32'h1);
    chk("post out",   32'(bh.out),   32'h55);
    bh.req = '0;

    // HOLD=0 rotation with all requesters active
    lanes = 32'hD3C2_B1A0;
    bz.req = 4'b1111; bz.data = lanes;
    for (int k = 0; k < 8; k++) begin
      step();
`ifdef D_TRIGGER_ARB_PRIO_EN
      eg = 4'b0001; eo = lanes[7:0];
`else
      eg = 4'(1 << (k % 4)); eo = lanes[(k % 4) * 8 +: 8];
`endif
      chk($sformatf("rr%0d grant", k), 32'(bz.grant), 32'(eg));
      chk($sformatf("rr%0d out", k),   32'(bz.out),   32'(eo));
    end
    chk("rr wr", 32'(bz.wr_count), 8);

    // req=1011 held: requester 2 skipped, or requester 0 always under priority
    seq = '{0, 1, 3, 0, 1, 3};
    bz.req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      step();
`ifdef D_TRIGGER_ARB_PRIO_EN
      eg = 4'b0001;
`else
      eg = 4'(1 << seq[k]);
`endif
      chk($sformatf("p%0d grant", k), 32'(bz.grant), 32'(eg));
    end
    bz.req = '0;

    // wr_count wrap over 256 writes from reset
    step();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    bz.req = 4'b0001;
    for (int k = 0; k < 255; k++) step();
    chk("wrap 255", 32'(bz.wr_count), 255);
    chk("wrap grant", 32'(bz.grant), 1);
    step();
    chk("wrap 0", 32'(bz.wr_count), 0);
    bz.req = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
